register_file_mc: RTL and testbench

- Parametrised successor to the core's scalar register file: multi-context, multi-read-port, byte-enabled register storage for the DSP/mixer datapath.
- Holds NUM_CTX independent register banks, e.g. one per audio channel or thread.
- Reads are registered with 1-cycle latency, and same-cycle writes are bypassed to them.
- A sequential clear engine zeroes storage after reset or on request, so the array itself needs no reset, which keeps it RAM-friendly.

---
 rtl/register_file_mc_if.sv | 29 ++
 rtl/register_file_mc.sv | 211 +++++++++++++++++++++
 tb/tb_register_file_mc.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mc_if.sv
// Bus bundle for the multi-context register file: read ports, write port,
// clear request and ready status.
interface register_file_mc_if #(
   parameter int REGADDR_WIDTH = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int CTX_WIDTH     = 1,
   parameter int NUM_RD        = 2
);
   logic [NUM_RD*CTX_WIDTH-1:0]     rd_ctx;
   logic [NUM_RD*REGADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0]    rd_data;
   logic                            wr_en;
   logic [CTX_WIDTH-1:0]            wr_ctx;
   logic [REGADDR_WIDTH-1:0]        wr_addr;
   logic [DATA_WIDTH-1:0]           wr_data;
   logic [DATA_WIDTH/8-1:0]         wr_be;
   logic                            clr_req;
   logic                            ready;

   modport master (
      output rd_ctx, rd_addr, wr_en, wr_ctx, wr_addr, wr_data, wr_be, clr_req,
      input  rd_data, ready
   );

   modport slave (
      input  rd_ctx, rd_addr, wr_en, wr_ctx, wr_addr, wr_data, wr_be, clr_req,
      output rd_data, ready
   );
endinterface

// File: rtl/register_file_mc.sv
// Multi-context, multi-read-port, byte-enabled register file with registered
// write-first reads and a sequential clear engine in place of an array reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing one flat entry per cycle; reads forced 0, writes dropped
// ST_READY | normal operation; clr_req restarts the clear sweep
module register_file_mc #(
   parameter int REGADDR_WIDTH = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_CTX       = 2,
   parameter int CTX_WIDTH     = 1,
   parameter int NUM_RD        = 2,
   parameter int ZERO_REG      = 1
) (
   input logic               clk_i,
   input logic               reset_n_i,
   register_file_mc_if.slave bus
);

   localparam int NUM_REGS = 1 << REGADDR_WIDTH;
   localparam int NUM_ENT  = NUM_CTX * NUM_REGS;
   localparam int ADDR_W   = $clog2(NUM_ENT);
   localparam int IDX_W    = $clog2(NUM_ENT) + 1;
   localparam int NUM_BE   = DATA_WIDTH / 8;
   localparam int FLAT_W   = CTX_WIDTH + REGADDR_WIDTH;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
   logic              ready_w;
   logic              clr_we;

   logic [DATA_WIDTH-1:0] mem_q [NUM_ENT];
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NUM_BE-1:0]     mem_wbe;

   logic [NUM_RD*CTX_WIDTH-1:0]     rd_ctx_w;
   logic [NUM_RD*REGADDR_WIDTH-1:0] rd_addr_w;
   logic                            wr_en_w;
   logic [CTX_WIDTH-1:0]            wr_ctx_w;
   logic [REGADDR_WIDTH-1:0]        wr_addr_w;
   logic [DATA_WIDTH-1:0]           wr_data_w;
   logic [NUM_BE-1:0]               wr_be_w;
   logic                            clr_req_w;

   logic              wr_commit;
   logic [ADDR_W-1:0] wr_ent;

   logic [DATA_WIDTH-1:0]        rd_d [NUM_RD];
   logic [DATA_WIDTH-1:0]        rd_q [NUM_RD];
   logic [NUM_RD*DATA_WIDTH-1:0] rd_flat;

   assign rd_ctx_w  = bus.rd_ctx;
   assign rd_addr_w = bus.rd_addr;
   assign wr_en_w   = bus.wr_en;
   assign wr_ctx_w  = bus.wr_ctx;
   assign wr_addr_w = bus.wr_addr;
   assign wr_data_w = bus.wr_data;
   assign wr_be_w   = bus.wr_be;
   assign clr_req_w = bus.clr_req;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (clr_req_w) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      ready_w = 1'b0;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: clr_we  = 1'b1;
         ST_READY: ready_w = 1'b1;
         default:  clr_we  = 1'b1;
      endcase
   end

   assign bus.ready = ready_w;

   // ------------------------------------------------------ write port mux
   function automatic logic ctx_valid(input logic [CTX_WIDTH-1:0] ctx);
      return 32'(ctx) < NUM_CTX;
   endfunction

   function automatic logic is_zero_reg(input logic [REGADDR_WIDTH-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   function automatic logic [ADDR_W-1:0] flat_ent(input logic [CTX_WIDTH-1:0] ctx,
                                                  input logic [REGADDR_WIDTH-1:0] addr);
      logic [FLAT_W-1:0] flat;
      flat = {ctx, addr};
      return ADDR_W'(flat);
   endfunction

   // A clear request in the same cycle wins over the user write.
   assign wr_commit = ready_w && wr_en_w && !clr_req_w &&
                      ctx_valid(wr_ctx_w) && !is_zero_reg(wr_addr_w);
   assign wr_ent    = flat_ent(wr_ctx_w, wr_addr_w);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wbe   = '0;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = ADDR_W'(clr_idx_q);
         mem_wbe   = '1;
      end else if (wr_commit) begin
         mem_we    = 1'b1;
         mem_waddr = wr_ent;
         mem_wdata = wr_data_w;
         mem_wbe   = wr_be_w;
      end
   end

   // Single write port, no reset: keeps the array mappable onto RAM.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < NUM_BE; b++) begin
            if (mem_wbe[b]) begin
               mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------- read ports
   function automatic logic [DATA_WIDTH-1:0] read_port(input int k);
      logic [CTX_WIDTH-1:0]     rctx;
      logic [REGADDR_WIDTH-1:0] raddr;
      logic [ADDR_W-1:0]        rent;
      logic [DATA_WIDTH-1:0]    word;
      rctx  = rd_ctx_w[k*CTX_WIDTH +: CTX_WIDTH];
      raddr = rd_addr_w[k*REGADDR_WIDTH +: REGADDR_WIDTH];
      rent  = flat_ent(rctx, raddr);
      word  = '0;
      if (ready_w && ctx_valid(rctx) && !is_zero_reg(raddr)) begin
         word = mem_q[rent];
         if (wr_commit && (wr_ent == rent)) begin
            for (int b = 0; b < NUM_BE; b++) begin
               if (wr_be_w[b]) begin
                  word[8*b +: 8] = wr_data_w[8*b +: 8];
               end
            end
         end
      end
      return word;
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd_d[k] = read_port(k);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NUM_RD; k++) begin
         if (!reset_n_i) begin
            rd_q[k] <= '0;
         end else begin
            rd_q[k] <= rd_d[k];
         end
      end
   end

   always_comb begin
      rd_flat = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_flat[k*DATA_WIDTH +: DATA_WIDTH] = rd_q[k];
      end
   end

   assign bus.rd_data = rd_flat;

endmodule

// File: tb/tb_register_file_mc.sv
// Bench for register_file_mc: three instances (default, ZERO_REG=0, three
// contexts) driven in lockstep and compared every cycle against an array model.
module tb_register_file_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        wr_en;
   logic        clr_req;
   logic [1:0]  wr_ctx;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [1:0]  rd_ctx  [2];
   logic [3:0]  rd_addr [2];

   register_file_mc_if #(.REGADDR_WIDTH(4), .DATA_WIDTH(32), .CTX_WIDTH(1), .NUM_RD(2)) if0 ();
   register_file_mc_if #(.REGADDR_WIDTH(4), .DATA_WIDTH(32), .CTX_WIDTH(1), .NUM_RD(2)) if1 ();
   register_file_mc_if #(.REGADDR_WIDTH(4), .DATA_WIDTH(32), .CTX_WIDTH(2), .NUM_RD(2)) if2 ();

   assign if0.wr_en   = wr_en;
   assign if0.clr_req = clr_req;
   assign if0.wr_ctx  = wr_ctx[0];
   assign if0.wr_addr = wr_addr;
   assign if0.wr_data = wr_data;
   assign if0.wr_be   = wr_be;
   assign if0.rd_ctx  = {rd_ctx[1][0], rd_ctx[0][0]};
   assign if0.rd_addr = {rd_addr[1], rd_addr[0]};

   assign if1.wr_en   = wr_en;
   assign if1.clr_req = clr_req;
   assign if1.wr_ctx  = wr_ctx[0];
   assign if1.wr_addr = wr_addr;
   assign if1.wr_data = wr_data;
   assign if1.wr_be   = wr_be;
   assign if1.rd_ctx  = {rd_ctx[1][0], rd_ctx[0][0]};
   assign if1.rd_addr = {rd_addr[1], rd_addr[0]};

   assign if2.wr_en   = wr_en;
   assign if2.clr_req = clr_req;
   assign if2.wr_ctx  = wr_ctx;
   assign if2.wr_addr = wr_addr;
   assign if2.wr_data = wr_data;
   assign if2.wr_be   = wr_be;
   assign if2.rd_ctx  = {rd_ctx[1], rd_ctx[0]};
   assign if2.rd_addr = {rd_addr[1], rd_addr[0]};

   register_file_mc #(.NUM_CTX(2), .CTX_WIDTH(1), .ZERO_REG(1))
      dut0 (.clk_i(clk), .reset_n_i(reset_n), .bus(if0));
   register_file_mc #(.NUM_CTX(2), .CTX_WIDTH(1), .ZERO_REG(0))
      dut1 (.clk_i(clk), .reset_n_i(reset_n), .bus(if1));
   register_file_mc #(.NUM_CTX(3), .CTX_WIDTH(2), .ZERO_REG(1))
      dut2 (.clk_i(clk), .reset_n_i(reset_n), .bus(if2));

   logic [63:0] rdv  [3];
   logic        rdyv [3];
   assign rdv[0]  = if0.rd_data;
   assign rdv[1]  = if1.rd_data;
   assign rdv[2]  = if2.rd_data;
   assign rdyv[0] = if0.ready;
   assign rdyv[1] = if1.ready;
   assign rdyv[2] = if2.ready;

   // reference model: plain arrays, a countdown of clear cycles left
   int          nctx [3] = '{2, 2, 3};
   bit          zr   [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m    [3][3][16];
   int          clr_left [3];
   logic [31:0] exp_rd   [3][2];
   logic        exp_rdy  [3];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wipe(input int d);
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 16; r++)
            m[d][c][r] = '0;
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         int total;
         int wc;
         int rc;
         bit rdy;
         total = nctx[d] * 16;
         wc    = (d < 2) ? int'(wr_ctx[0]) : int'(wr_ctx);
         if (!reset_n) begin
            clr_left[d]  = total;
            wipe(d);
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
            exp_rdy[d]   = 1'b0;
         end else begin
            rdy = (clr_left[d] == 0);
            if (rdy && wr_en && !clr_req && wc < nctx[d] && !(zr[d] && wr_addr == 4'd0))
               for (int b = 0; b < 4; b++)
                  if (wr_be[b]) m[d][wc][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            for (int k = 0; k < 2; k++) begin
               rc = (d < 2) ? int'(rd_ctx[k][0]) : int'(rd_ctx[k]);
               if (rdy && rc < nctx[d] && !(zr[d] && rd_addr[k] == 4'd0))
                  exp_rd[d][k] = m[d][rc][rd_addr[k]];
               else
                  exp_rd[d][k] = '0;
            end
            if (rdy && clr_req) begin
               clr_left[d] = total;
               wipe(d);
            end else if (!rdy) begin
               clr_left[d]--;
            end
            exp_rdy[d] = (clr_left[d] == 0);
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("ready[%0d]", d), {31'b0, rdyv[d]}, {31'b0, exp_rdy[d]});
         for (int k = 0; k < 2; k++)
            chk($sformatf("rd_data[%0d][%0d]", d, k), rdv[d][32*k +: 32], exp_rd[d][k]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_wr(input bit en, input int ctx, input int addr,
                         input logic [31:0] data, input logic [3:0] be);
      wr_en   = en;
      wr_ctx  = 2'(ctx);
      wr_addr = 4'(addr);
      wr_data = data;
      wr_be   = be;
   endtask

   task automatic set_rd(input int c0, input int a0, input int c1, input int a1);
      rd_ctx[0]  = 2'(c0);
      rd_addr[0] = 4'(a0);
      rd_ctx[1]  = 2'(c1);
      rd_addr[1] = 4'(a1);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         clr_left[d] = nctx[d] * 16;
         exp_rd[d][0] = '0;
         exp_rd[d][1] = '0;
         exp_rdy[d] = 1'b0;
         wipe(d);
      end
      reset_n = 1'b0;
      clr_req = 1'b0;
      set_wr(0, 0, 0, 32'h0, 4'h0);
      set_rd(0, 0, 0, 0);
      #2;
      step();
      step();
      chk("reset_ready", {31'b0, if0.ready}, 32'd0);
      chk("reset_rd", rdv[0][31:0], 32'd0);

      // clear after release: exactly 32 edges for two contexts
      reset_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         step();
         chk("release_ready", {31'b0, if0.ready}, (i == 32) ? 32'd1 : 32'd0);
      end
      set_rd(1, 5, 1, 5);
      step();
      chk("post_clear_p0", rdv[0][31:0], 32'd0);
      chk("post_clear_p1", rdv[0][63:32], 32'd0);
      repeat (15) step();
      chk("ctx3_ready", {31'b0, if2.ready}, 32'd1);

      // full write with same-cycle bypass read
      set_wr(1, 0, 3, 32'hDEADBEEF, 4'hF);
      set_rd(0, 3, 1, 3);
      step();
      chk("bypass_p0", rdv[0][31:0], 32'hDEADBEEF);
      chk("bypass_p1_other_ctx", rdv[0][63:32], 32'd0);

      // partial byte-enable write merged through the bypass
      set_wr(1, 0, 3, 32'h11223344, 4'h5);
      set_rd(0, 3, 0, 3);
      step();
      chk("byte_merge_p0", rdv[0][31:0], 32'hDE22BE44);
      chk("byte_merge_p1", rdv[0][63:32], 32'hDE22BE44);

      // register 0 with and without ZERO_REG
      set_wr(1, 0, 0, 32'hFFFFFFFF, 4'hF);
      set_rd(0, 0, 0, 0);
      step();
      set_wr(0, 0, 0, 32'h0, 4'h0);
      step();
      chk("zero_reg_on", rdv[0][31:0], 32'd0);
      chk("zero_reg_off", rdv[1][31:0], 32'hFFFFFFFF);

      // fill, then clear colliding with a write; mid-clear request ignored
      set_wr(1, 1, 7, 32'h77777777, 4'hF); step();
      set_wr(1, 0, 9, 32'h99999999, 4'hF); step();
      set_wr(1, 1, 2, 32'h22222222, 4'hF); step();
      set_wr(0, 0, 0, 32'h0, 4'h0);
      set_rd(1, 7, 0, 9);
      step();
      chk("filled_p0", rdv[0][31:0], 32'h77777777);
      chk("filled_p1", rdv[0][63:32], 32'h99999999);
      clr_req = 1'b1;
      set_wr(1, 1, 7, 32'h00000055, 4'hF);
      step();
      chk("clr_ready_low", {31'b0, if0.ready}, 32'd0);
      set_wr(0, 0, 0, 32'h0, 4'h0);
      for (int i = 1; i <= 32; i++) begin
         clr_req = (i == 10);
         step();
         chk("clr_ready", {31'b0, if0.ready}, (i == 32) ? 32'd1 : 32'd0);
      end
      clr_req = 1'b0;
      repeat (16) step();
      set_rd(1, 7, 0, 9);
      step();
      chk("cleared_r7", rdv[0][31:0], 32'd0);
      chk("cleared_r9", rdv[0][63:32], 32'd0);
      set_rd(1, 2, 0, 3);
      step();
      chk("cleared_r2", rdv[0][31:0], 32'd0);
      chk("cleared_r3", rdv[0][63:32], 32'd0);

      // reset mid-clear restarts the sweep
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (20) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         step();
         chk("restart_ready", {31'b0, if0.ready}, (i == 32) ? 32'd1 : 32'd0);
      end
      repeat (16) step();

      // out-of-range context on the three-context instance
      set_wr(1, 3, 4, 32'hA5A5A5A5, 4'hF);
      set_rd(3, 4, 2, 4);
      step();
      chk("ctx3_bypass", rdv[2][31:0], 32'd0);
      set_wr(1, 2, 4, 32'h3C3C3C3C, 4'hF);
      step();
      set_wr(0, 0, 0, 32'h0, 4'h0);
      step();
      chk("ctx3_read", rdv[2][31:0], 32'd0);
      chk("ctx2_read", rdv[2][63:32], 32'h3C3C3C3C);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         clr_req = ($urandom_range(0, 79) == 0);
         set_wr($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                $urandom(), 4'($urandom_range(0, 15)));
         set_rd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
